case_7_mul_pipe_sat: RTL

Parametrised, pipelined successor to the combinational signed multiplier cores in the case_7 datapath.
- Adds per-transaction operand signedness, a rounding right-shift and optional output saturation with an overflow flag.
- Adds a valid/ready handshake with backpressure, so the block sits between a producer FIFO stage and a downstream accumulator that may stall.

---
 rtl/case_7_mul_pkg.sv | 31 +++
 rtl/case_7_mul_rnd_sat.sv | 61 ++++++
 rtl/case_7_mul_pipe_sat.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/case_7_mul_pkg.sv
// case_7_mul_pkg: operand-mode encodings and width/bound helpers shared by the
// pipelined saturating multiplier.
`default_nettype none

package case_7_mul_pkg;

    // bit0 = din0 signed, bit1 = din1 signed
    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_US = 2'b10;
    localparam logic [1:0] MODE_SS = 2'b11;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    function automatic logic res_signed(input logic [1:0] m);
        return (m & MODE_SS) != MODE_UU;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w, input logic sgn);
        return sgn ? ((64'sd1 <<< (w - 1)) - 64'sd1) : ((64'sd1 <<< w) - 64'sd1);
    endfunction

    function automatic logic signed [63:0] sat_min(input int w, input logic sgn);
        return sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/case_7_mul_rnd_sat.sv
// case_7_mul_rnd_sat: rounding right-shift of the full product followed by
// saturation (or wrap) to the output width, with an overflow flag.
`default_nettype none

module case_7_mul_rnd_sat
    import case_7_mul_pkg::*;
#(
    parameter int PW    = 17,
    parameter int DW    = 9,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic signed [PW-1:0] prod_i,
    input  logic                 sgn_i,
    output logic [DW-1:0]        dout_o,
    output logic                 ovf_o
);

    logic signed [PW:0]  w_r;
    logic signed [63:0]  w_r64;

    if (SHIFT > 0) begin : g_rnd
        // Adding half an LSB before the arithmetic shift rounds half toward +inf.
        localparam logic signed [PW:0] c_HALF = {{PW{1'b0}}, 1'b1} << (SHIFT - 1);
        logic signed [PW:0] w_sum;
        assign w_sum = {prod_i[PW-1], prod_i} + c_HALF;
        assign w_r   = w_sum >>> SHIFT;
    end else begin : g_nornd
        assign w_r = {prod_i[PW-1], prod_i};
    end

    assign w_r64 = 64'(w_r);

    if (SAT != 0) begin : g_sat
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        assign w_max = sat_max(DW, sgn_i);
        assign w_min = sat_min(DW, sgn_i);

        always_comb begin
            dout_o = w_r64[DW-1:0];
            ovf_o  = 1'b0;
            if (w_r64 > w_max) begin
                dout_o = w_max[DW-1:0];
                ovf_o  = 1'b1;
            end else if (w_r64 < w_min) begin
                dout_o = w_min[DW-1:0];
                ovf_o  = 1'b1;
            end
        end
    end else begin : g_wrap
        logic signed [63:0] w_ext;
        assign dout_o = w_r64[DW-1:0];
        assign w_ext  = sgn_i ? {{(64-DW){w_r64[DW-1]}}, w_r64[DW-1:0]}
                              : {{(64-DW){1'b0}},        w_r64[DW-1:0]};
        assign ovf_o  = (w_ext != w_r64);
    end

endmodule

`default_nettype wire

// File: rtl/case_7_mul_pipe_sat.sv
// case_7_mul_pipe_sat: pipelined multiplier with per-transaction signedness,
// rounding shift, saturation and a stall-as-a-unit valid/ready handshake.
`default_nettype none

module case_7_mul_pipe_sat
    import case_7_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 9,
    parameter int SHIFT      = 0,
    parameter int SAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic [1:0]            mode,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int c_PW     = prod_width(din0_WIDTH, din1_WIDTH);
    // ID is an instance tag only and never alters the datapath.
    localparam int c_STAGES = NUM_STAGE + 0 * ID;

    logic                  w_adv;
    logic                  w_acc;
    logic [din0_WIDTH-1:0] w_op0;
    logic [din1_WIDTH-1:0] w_op1;
    logic [1:0]            w_mode;
    logic                  w_s0;
    logic                  w_s1;
    logic signed [c_PW-1:0] w_a;
    logic signed [c_PW-1:0] w_b;
    logic signed [c_PW-1:0] w_prod;
    logic                  w_psgn;
    logic                  w_fin_vld;
    logic signed [c_PW-1:0] w_fin_prod;
    logic                  w_fin_sgn;
    logic [dout_WIDTH-1:0] w_rs_dout;
    logic                  w_rs_ovf;

    logic                  out_vld_q;
    logic [dout_WIDTH-1:0] dout_q;
    logic                  ovf_q;

    assign w_adv  = ce & ~reset & (~out_vld_q | out_rdy);
    assign w_acc  = in_vld & w_adv;
    assign in_rdy = w_adv;

    assign w_s0   = ((w_mode & MODE_SU) != MODE_UU) & w_op0[din0_WIDTH-1];
    assign w_s1   = ((w_mode & MODE_US) != MODE_UU) & w_op1[din1_WIDTH-1];
    assign w_a    = c_PW'($signed({w_s0, w_op0}));
    assign w_b    = c_PW'($signed({w_s1, w_op1}));
    assign w_prod = w_a * w_b;
    assign w_psgn = res_signed(w_mode);

    if (c_STAGES == 1) begin : g_comb
        assign w_op0      = din0;
        assign w_op1      = din1;
        assign w_mode     = mode;
        assign w_fin_vld  = w_acc;
        assign w_fin_prod = w_prod;
        assign w_fin_sgn  = w_psgn;
    end else begin : g_pipe
        logic                  vld0_q;
        logic [din0_WIDTH-1:0] op0_q;
        logic [din1_WIDTH-1:0] op1_q;
        logic [1:0]            mode_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld0_q <= 1'b0;
                op0_q  <= '0;
                op1_q  <= '0;
                mode_q <= MODE_UU;
            end else if (w_adv) begin
                vld0_q <= w_acc;
                op0_q  <= din0;
                op1_q  <= din1;
                mode_q <= mode;
            end
        end

        assign w_op0  = op0_q;
        assign w_op1  = op1_q;
        assign w_mode = mode_q;

        if (c_STAGES == 2) begin : g_direct
            assign w_fin_vld  = vld0_q;
            assign w_fin_prod = w_prod;
            assign w_fin_sgn  = w_psgn;
        end else begin : g_mid
            localparam int c_MID = c_STAGES - 2;
            logic                   mid_vld_q  [c_MID];
            logic                   mid_sgn_q  [c_MID];
            logic signed [c_PW-1:0] mid_prod_q [c_MID];

            // Product delay line; the whole pipe shifts together on advance.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < c_MID; k++) begin
                        mid_vld_q[k]  <= 1'b0;
                        mid_sgn_q[k]  <= 1'b0;
                        mid_prod_q[k] <= '0;
                    end
                end else if (w_adv) begin
                    mid_vld_q[0]  <= vld0_q;
                    mid_sgn_q[0]  <= w_psgn;
                    mid_prod_q[0] <= w_prod;
                    for (int k = 1; k < c_MID; k++) begin
                        mid_vld_q[k]  <= mid_vld_q[k-1];
                        mid_sgn_q[k]  <= mid_sgn_q[k-1];
                        mid_prod_q[k] <= mid_prod_q[k-1];
                    end
                end
            end

            assign w_fin_vld  = mid_vld_q[c_MID-1];
            assign w_fin_prod = mid_prod_q[c_MID-1];
            assign w_fin_sgn  = mid_sgn_q[c_MID-1];
        end
    end

    case_7_mul_rnd_sat #(
        .PW    (c_PW),
        .DW    (dout_WIDTH),
        .SHIFT (SHIFT),
        .SAT   (SAT)
    ) u_rnd_sat (
        .prod_i (w_fin_prod),
        .sgn_i  (w_fin_sgn),
        .dout_o (w_rs_dout),
        .ovf_o  (w_rs_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (w_adv) begin
            out_vld_q <= w_fin_vld;
            dout_q    <= w_rs_dout;
            ovf_q     <= w_rs_ovf;
        end
    end

    assign out_vld = out_vld_q;
    assign dout    = dout_q;
    assign ovf     = ovf_q;

endmodule

`default_nettype wire
